multicycle_alu: RTL and testbench

- Parametrised, registered successor to the processor's combinational ALU. Same 16-opcode map on a 4-bit control field, but WIDTH is configurable.
- Multiply, divide and remainder run on an iterative shift-add / restoring-divide engine instead of single-cycle `*`, `/`, `%`.
- Sits between the multicycle control FSM and the register file or PC logic, with a valid/ready handshake on both sides.
- Divide-by-zero and signed overflow produce defined results.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_muldiv_iter.sv | 78 +++++++
 rtl/multicycle_alu.sv | 151 +++++++++++++++
 tb/tb_multicycle_alu.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU datapath and control decoder: opcodes,
// handshake state encoding and engine modes.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6;
  localparam logic [3:0] OP_EQ  = 4'd7;
  localparam logic [3:0] OP_NE  = 4'd8;
  localparam logic [3:0] OP_GT  = 4'd9;
  localparam logic [3:0] OP_GE  = 4'd10;
  localparam logic [3:0] OP_LT  = 4'd11;
  localparam logic [3:0] OP_LE  = 4'd12;
  localparam logic [3:0] OP_MUL = 4'd13;
  localparam logic [3:0] OP_DIV = 4'd14;
  localparam logic [3:0] OP_REM = 4'd15;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic is_compare(input logic [3:0] op);
    return (op >= OP_EQ) && (op <= OP_LE);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned engine: shift-add multiply or restoring divide, one bit
// per cycle. *_c outputs present the values the current iteration will write.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_c,
  output logic [WIDTH-1:0] product_c,
  output logic [WIDTH-1:0] quotient_c,
  output logic [WIDTH-1:0] remainder_c
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic             run_q;
  logic             mode_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH:0]   sh_c;

  // mul: acc accumulates, a is the shifting multiplicand, b the multiplier.
  // div: acc is the partial remainder, a shifts dividend out / quotient in.
  always_comb begin
    acc_d = acc_q;
    a_d   = a_q;
    b_d   = b_q;
    sh_c  = {acc_q, a_q[WIDTH-1]};
    if (mode_q == MODE_MUL) begin
      acc_d = b_q[0] ? (acc_q + a_q) : acc_q;
      a_d   = a_q << 1;
      b_d   = b_q >> 1;
    end else if (sh_c >= {1'b0, b_q}) begin
      acc_d = WIDTH'(sh_c - {1'b0, b_q});
      a_d   = {a_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_d = WIDTH'(sh_c);
      a_d   = {a_q[WIDTH-2:0], 1'b0};
    end
    done_c      = run_q && (cnt_q == '0);
    product_c   = acc_d;
    quotient_c  = a_d;
    remainder_c = acc_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q  <= 1'b0;
      mode_q <= MODE_MUL;
      cnt_q  <= '0;
      acc_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
    end else if (start_i) begin
      run_q  <= 1'b1;
      mode_q <= mode_i;
      cnt_q  <= CNT_W'(WIDTH - 1);
      acc_q  <= '0;
      a_q    <= a_i;
      b_q    <= b_i;
    end else if (run_q) begin
      acc_q <= acc_d;
      a_q   <= a_d;
      b_q   <= b_d;
      cnt_q <= cnt_q - CNT_W'(1);
      if (cnt_q == '0) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// Registered ALU with valid/ready handshake; single-cycle ops finish at
// accept, MUL/DIV/REM iterate WIDTH cycles on the shared engine.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             branch_res,
  output logic             busy
);

  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONES = '1;

  state_e           state_q, state_d;
  logic             div_q, div_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             br_q, br_d;
  logic             in_ready_q, busy_q, out_valid_q;

  logic [WIDTH-1:0] alu_c, abs1_c, abs2_c, iter_res_c;
  logic             special_c, start_c, mode_c;
  logic             done_c;
  logic [WIDTH-1:0] product_c, quotient_c, remainder_c;

  assign abs1_c    = in1[WIDTH-1] ? -in1 : in1;
  assign abs2_c    = in2[WIDTH-1] ? -in2 : in2;
  assign special_c = ((op == OP_DIV) || (op == OP_REM)) &&
                     ((in2 == '0) || ((in1 == SMIN) && (in2 == ONES)));

  // Single-cycle results, including the resolved divide special cases.
  always_comb begin
    alu_c = '0;
    case (op)
      OP_ADD:  alu_c = in1 + in2;
      OP_SUB:  alu_c = in1 - in2;
      OP_AND:  alu_c = in1 & in2;
      OP_OR:   alu_c = in1 | in2;
      OP_XOR:  alu_c = in1 ^ in2;
      OP_SLL:  alu_c = in1 << in2[SHAMT_W-1:0];
      OP_SRL:  alu_c = in1 >> in2[SHAMT_W-1:0];
      OP_EQ:   alu_c = WIDTH'(in1 == in2);
      OP_NE:   alu_c = WIDTH'(in1 != in2);
      OP_GT:   alu_c = WIDTH'($signed(in1) >  $signed(in2));
      OP_GE:   alu_c = WIDTH'($signed(in1) >= $signed(in2));
      OP_LT:   alu_c = WIDTH'($signed(in1) <  $signed(in2));
      OP_LE:   alu_c = WIDTH'($signed(in1) <= $signed(in2));
      OP_DIV:  alu_c = (in2 == '0) ? ONES : SMIN;
      OP_REM:  alu_c = (in2 == '0) ? in1 : '0;
      default: alu_c = '0;
    endcase
  end

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_c),
    .mode_i      (mode_c),
    .a_i         (abs1_c),
    .b_i         (abs2_c),
    .done_c      (done_c),
    .product_c   (product_c),
    .quotient_c  (quotient_c),
    .remainder_c (remainder_c)
  );

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    neg_d      = neg_q;
    out_d      = out_q;
    br_d       = br_q;
    start_c    = 1'b0;
    mode_c     = MODE_MUL;
    iter_res_c = (state_q == ST_MUL) ? product_c : (div_q ? quotient_c : remainder_c);
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (op == OP_MUL) begin
            start_c = 1'b1;
            neg_d   = in1[WIDTH-1] ^ in2[WIDTH-1];
            br_d    = 1'b0;
            state_d = ST_MUL;
          end else if (((op == OP_DIV) || (op == OP_REM)) && !special_c) begin
            start_c = 1'b1;
            mode_c  = MODE_DIV;
            div_d   = (op == OP_DIV);
            // Quotient sign is the xor of signs; remainder follows the dividend.
            neg_d   = (op == OP_DIV) ? (in1[WIDTH-1] ^ in2[WIDTH-1]) : in1[WIDTH-1];
            br_d    = 1'b0;
            state_d = ST_DIV;
          end else begin
            out_d   = alu_c;
            br_d    = is_compare(op) & alu_c[0];
            state_d = ST_DONE;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        if (done_c) begin
          out_d   = neg_q ? -iter_res_c : iter_res_c;
          br_d    = 1'b0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      div_q       <= 1'b0;
      neg_q       <= 1'b0;
      out_q       <= '0;
      br_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      neg_q       <= neg_d;
      out_q       <= out_d;
      br_q        <= br_d;
      in_ready_q  <= (state_d == ST_IDLE);
      busy_q      <= (state_d == ST_MUL) || (state_d == ST_DIV);
      out_valid_q <= (state_d == ST_DONE);
    end
  end

  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign out_valid  = out_valid_q;
  assign out        = out_q;
  assign branch_res = br_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed vector bench for multicycle_alu at WIDTH=32.
module tb_multicycle_alu;
  import alu_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic        branch_res;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        br;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  multicycle_alu #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .in1        (in1),
    .in2        (in2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out        (out),
    .branch_res (branch_res),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic [3:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input logic br,
                         input int lat);
    vec_t v;
    v.name = name; v.op = o; v.a = a; v.b = b; v.exp = exp; v.br = br; v.lat = lat;
    vecs.push_back(v);
  endtask

  // Issue one op, scramble inputs after accept, measure latency, then consume.
  task automatic run_op(input string name, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input logic br,
                        input int lat_exp);
    int   lat;
    logic hs_ok;
    @(negedge clk);
    check({name, " in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; op = o; in1 = a; in2 = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in1 = $urandom; in2 = $urandom; op = 4'($urandom_range(0, 15));
    lat   = 1;
    hs_ok = 1'b1;
    while (!out_valid && lat < 200) begin
      if (!busy || in_ready) hs_ok = 1'b0;
      @(negedge clk);
      lat++;
      in1 = $urandom;
    end
    check({name, " latency"}, 32'(lat), 32'(lat_exp));
    check({name, " out"}, out, exp);
    check({name, " branch_res"}, 32'(branch_res), 32'(br));
    check({name, " busy/in_ready during op"}, 32'(hs_ok), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, " out_valid after consume"}, 32'(out_valid), 32'd0);
    check({name, " out kept after consume"}, out, exp);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; op = '0; in1 = '0; in2 = '0; out_ready = 1'b0;

    add_vec("add",        OP_ADD, 32'd7,          -32'sd3,        32'd4,          1'b0, 1);
    add_vec("sll",        OP_SLL, 32'd1,          32'h21,         32'd2,          1'b0, 1);
    add_vec("srl",        OP_SRL, 32'h8000_0000,  32'd31,         32'd1,          1'b0, 1);
    add_vec("and",        OP_AND, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000,  1'b0, 1);
    add_vec("or",         OP_OR,  32'h0000_F0F0,  32'h0000_0F0F,  32'h0000_FFFF,  1'b0, 1);
    add_vec("xor",        OP_XOR, 32'h0000_00FF,  32'h0000_000F,  32'h0000_00F0,  1'b0, 1);
    add_vec("lt",         OP_LT,  -32'sd5,        32'd3,          32'd1,          1'b1, 1);
    add_vec("gt",         OP_GT,  -32'sd5,        32'd3,          32'd0,          1'b0, 1);
    add_vec("eq",         OP_EQ,  32'd5,          32'd5,          32'd1,          1'b1, 1);
    add_vec("ne",         OP_NE,  32'd5,          32'd5,          32'd0,          1'b0, 1);
    add_vec("ge",         OP_GE,  32'd3,          32'd3,          32'd1,          1'b1, 1);
    add_vec("le",         OP_LE,  32'd4,          32'd3,          32'd0,          1'b0, 1);
    add_vec("mul",        OP_MUL, -32'sd7,        32'd6,          32'hFFFF_FFD6,  1'b0, 33);
    add_vec("mul_wrap",   OP_MUL, 32'h0001_0000,  32'h0001_0000,  32'h0000_0000,  1'b0, 33);
    add_vec("mul_min",    OP_MUL, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0, 33);
    add_vec("div",        OP_DIV, -32'sd7,        32'd2,          32'hFFFF_FFFD,  1'b0, 33);
    add_vec("rem",        OP_REM, -32'sd7,        32'd2,          32'hFFFF_FFFF,  1'b0, 33);
    add_vec("div_negb",   OP_DIV, 32'd7,          -32'sd2,        32'hFFFF_FFFD,  1'b0, 33);
    add_vec("rem_negb",   OP_REM, 32'd7,          -32'sd2,        32'd1,          1'b0, 33);
    add_vec("div_min2",   OP_DIV, 32'h8000_0000,  32'd2,          32'hC000_0000,  1'b0, 33);
    add_vec("div_zero",   OP_DIV, 32'd100,        32'd0,          32'hFFFF_FFFF,  1'b0, 1);
    add_vec("rem_zero",   OP_REM, 32'd100,        32'd0,          32'd100,        1'b0, 1);
    add_vec("div_ovf",    OP_DIV, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0, 1);
    add_vec("rem_ovf",    OP_REM, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b0, 1);

    repeat (2) @(negedge clk);
    check("reset out",        out,                 32'd0);
    check("reset out_valid",  32'(out_valid),      32'd0);
    check("reset in_ready",   32'(in_ready),       32'd1);
    check("reset busy",       32'(busy),           32'd0);
    check("reset branch_res", 32'(branch_res),     32'd0);
    rst = 1'b0;

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].br, vecs[i].lat);

    // Result held under back-pressure.
    @(negedge clk);
    in_valid = 1'b1; op = OP_SUB; in1 = 32'd10; in2 = 32'd20;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in1 = 32'd0;
    for (int k = 0; k < 5; k++) begin
      check("hold out_valid", 32'(out_valid), 32'd1);
      check("hold out",       out,            32'hFFFF_FFF6);
      check("hold in_ready",  32'(in_ready),  32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("hold released out_valid", 32'(out_valid), 32'd0);

    // Reset in the middle of a multiply aborts it.
    in_valid = 1'b1; op = OP_MUL; in1 = -32'sd7; in2 = 32'd6;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("mid-mul busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort out",       out,            32'd0);
    check("abort in_ready",  32'(in_ready),  32'd1);
    check("abort busy",      32'(busy),      32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("add_after_rst", OP_ADD, 32'd1, 32'd1, 32'd2, 1'b0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
